// File: rtl/implies_delay_range.sv
// Bounded-delay implication checker: precond |-> ##[MIN_DLY:MAX_DLY] prop, with overlapping attempts.
// Optional macro CHK_STICKY_FAIL_EN makes fail sticky until rst.
module implies_delay_range #(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 4,
  parameter int CNT_W   = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_cond,
  input  logic             precond,
  input  logic             prop,
  output logic             sample,
  output logic             fail,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt
);

  if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > 32) begin : g_bad_params
    $error("implies_delay_range: illegal MIN_DLY/MAX_DLY combination");
  end

  // pend[k]: an attempt launched k cycles ago is still open
  logic [MAX_DLY:1] pend, pend_nxt, in_win;
  logic             discharge, expire;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    in_win = '0;
    for (int k = MIN_DLY; k <= MAX_DLY; k++) in_win[k] = pend[k];
    discharge = prop & (|in_win);
    // the oldest slot is always in window, so prop discharges rather than expires it
    expire = pend[MAX_DLY] & ~prop;
    pend_nxt    = '0;
    pend_nxt[1] = precond;
    for (int k = 1; k < MAX_DLY; k++) pend_nxt[k+1] = pend[k] & ~(prop & in_win[k]);
    cnt_nxt = '0;
    for (int k = 1; k <= MAX_DLY; k++) cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      sample   <= 1'b0;
      fail     <= 1'b0;
      busy     <= 1'b0;
      pend_cnt <= '0;
    end else if (!enable_cond) begin
      // disabling discards open attempts silently
      pend     <= '0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      pend_cnt <= '0;
`ifdef CHK_STICKY_FAIL_EN
      fail     <= fail;
`else
      fail     <= 1'b0;
`endif
    end else begin
      pend     <= pend_nxt;
      sample   <= discharge;
`ifdef CHK_STICKY_FAIL_EN
      fail     <= fail | expire;
`else
      fail     <= expire;
`endif
      busy     <= |pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_implies_delay_range.sv
// Bench for implies_delay_range: directed scenarios plus random traffic against an attempt-list model.
module tb_implies_delay_range;
  localparam int MIN_D = 2;
  localparam int MAX_D = 4;
  localparam int CW    = $clog2(MAX_D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_cond = 1'b0, precond = 1'b0, prop = 1'b0;
  logic          sample, fail, busy;
  logic [CW-1:0] pend_cnt;

  int compared = 0;
  int mismatched = 0;

  // model: list of ages of open attempts
  int q[$];
  bit exp_sample, exp_fail;
  int exp_cnt;
  int peak;

  implies_delay_range #(.MIN_DLY(MIN_D), .MAX_DLY(MAX_D)) dut (
    .clk(clk), .rst(rst), .enable_cond(enable_cond), .precond(precond), .prop(prop),
    .sample(sample), .fail(fail), .busy(busy), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":sample"}, 32'(sample), 32'(exp_sample));
    chk({tag, ":fail"}, 32'(fail), 32'(exp_fail));
    chk({tag, ":busy"}, 32'(busy), 32'(exp_cnt != 0));
    chk({tag, ":pend_cnt"}, 32'(pend_cnt), 32'(exp_cnt));
  endtask

  task automatic model_reset();
    q.delete();
    exp_sample = 0;
    exp_fail   = 0;
    exp_cnt    = 0;
  endtask

  task automatic model_step(input bit en, input bit pc, input bit pr);
    int nq[$];
    bit s = 0;
    bit f = 0;
    if (!en) begin
      q.delete();
      exp_sample = 0;
`ifndef CHK_STICKY_FAIL_EN
      exp_fail = 0;
`endif
      exp_cnt = 0;
      return;
    end
    foreach (q[i]) begin
      if (pr && q[i] >= MIN_D) s = 1;
      else if (q[i] == MAX_D) f = 1;
      else nq.push_back(q[i] + 1);
    end
    if (pc) nq.push_back(1);
    q = nq;
    exp_sample = s;
`ifdef CHK_STICKY_FAIL_EN
    exp_fail = exp_fail | f;
`else
    exp_fail = f;
`endif
    exp_cnt = q.size();
  endtask

  task automatic step(input bit en, input bit pc, input bit pr);
    enable_cond = en;
    precond     = pc;
    prop        = pr;
    @(posedge clk);
    model_step(en, pc, pr);
    #1;
    check_all("step");
    if (32'(pend_cnt) > peak) peak = 32'(pend_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    enable_cond = 0;
    precond = 0;
    prop = 0;
    model_reset();
    #2;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // 1: discharge at earliest allowed delay
    step(1, 1, 0); chk("s1_cnt1", 32'(pend_cnt), 1);
    step(1, 0, 0); chk("s1_cnt2", 32'(pend_cnt), 1);
    step(1, 0, 1); chk("s1_sample", 32'(sample), 1); chk("s1_cnt3", 32'(pend_cnt), 0);
    step(1, 0, 0); chk("s1_sample_off", 32'(sample), 0);

    // 2: prop too early is ignored, attempt expires
    do_reset();
    step(1, 1, 0);
    step(1, 0, 1); chk("s2_early_sample", 32'(sample), 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("s2_fail", 32'(fail), 1); chk("s2_busy", 32'(busy), 0);

    // 3: two overlapping attempts share one prop
    do_reset();
    step(1, 1, 0); chk("s3_cnt1", 32'(pend_cnt), 1);
    step(1, 1, 0); chk("s3_cnt2", 32'(pend_cnt), 2);
    step(1, 0, 0); chk("s3_cnt3", 32'(pend_cnt), 2);
    step(1, 0, 1); chk("s3_sample", 32'(sample), 1); chk("s3_cnt4", 32'(pend_cnt), 0);

    // 4: disable discards attempt without fail
    do_reset();
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0); chk("s4_busy", 32'(busy), 0); chk("s4_cnt", 32'(pend_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("s4_nofail", 32'(fail), 0);
    end

    // 5: precond held high saturates, mid-run async reset
    do_reset();
    peak = 0;
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    chk("s5_peak", 32'(peak), 4);
    chk("s5_fail", 32'(fail), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("s5_midrst");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0); chk("s5_restart_cnt", 32'(pend_cnt), 0);

    // 6: same-cycle precond/prop does not discharge the new attempt
    do_reset();
    step(1, 1, 1); chk("s6_cnt", 32'(pend_cnt), 1); chk("s6_sample", 32'(sample), 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 19) != 0, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
